// File: rtl/instruction_fetch.sv
// Fetch stage feeding the MIPS decode stage.
// Owns the PC, issues word-aligned requests to instruction memory (variable
// latency), hands {inst, inst_pc, inst_pc4} to decode over valid/ready, and
// squashes wrong-path fetches when the datapath redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  // FETCH: request in flight on the correct path, output register empty.
  // DRAIN: request in flight on a squashed path; its data must be dropped.
  // HOLD:  output register full, no request until decode takes it.
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] redirect_aligned;
  logic [31:0] pc_seq;

  // Redirect targets are forced to a word boundary so pc[1:0] stays 00.
  assign redirect_aligned = redirect_pc & ALIGN_MASK;
  assign pc_seq           = pc + 32'd4;

  // The address never moves while a request is outstanding because pc only
  // changes on an ack or while no request is being made.
  assign imem_addr = pc;
  assign imem_req  = !rst && ((state == FETCH) || (state == DRAIN));

  // Single state machine: PC, pending redirect target and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC_ALIGNED;
      tgt        <= 32'h0000_0000;
      inst_valid <= 1'b0;
      inst       <= 32'h0000_0000;
      inst_pc    <= 32'h0000_0000;
      inst_pc4   <= 32'h0000_0000;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              pc <= redirect_aligned;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_pc4   <= pc_seq;
              inst_valid <= 1'b1;
              pc         <= pc_seq;
              state      <= HOLD;
            end
          end else if (redirect_valid) begin
            tgt   <= redirect_aligned;
            state <= DRAIN;
          end
        end

        DRAIN: begin
          if (imem_ack) begin
            pc    <= redirect_valid ? redirect_aligned : tgt;
            state <= FETCH;
          end else if (redirect_valid) begin
            tgt <= redirect_aligned;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            inst_valid <= 1'b0;
            pc         <= redirect_aligned;
            state      <= FETCH;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= FETCH;
          end
        end

        default: begin
          inst_valid <= 1'b0;
          state      <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: cycle vectors with expected outputs after
// each edge, plus a queue of instructions decode is expected to accept.
module tb_instruction_fetch;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic        push;
    logic        flush;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks   = 0;
  int   failures = 0;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[17:2]};
  endfunction

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic ack, input logic rdy, input logic push,
                              input logic flush, input logic ereq,
                              input logic [31:0] eaddr, input logic evalid,
                              input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.ack = ack; v.rdy = rdy;
    v.push = push; v.flush = flush; v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_valid = evalid; v.exp_pc = epc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, then check the outputs.
  task automatic applyStimulus(input vec_t v, input int idx);
    sb_t item;
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    inst_ready     = v.rdy;
    imem_ack       = v.ack;
    imem_rdata     = v.ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    if (v.push) begin
      item.inst = mem_word(v.exp_pc);
      item.pc   = v.exp_pc;
      item.pc4  = v.exp_pc + 32'd4;
      sb.push_back(item);
    end
    if (v.flush) begin
      if (sb.size() == 0) checkOutput($sformatf("v%0d_flush_sb_empty", idx), 32'd0, 32'd1);
      else void'(sb.pop_front());
    end else if (!v.rst && !v.rv && v.rdy && inst_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput($sformatf("v%0d_unexpected_accept", idx), 32'd1, 32'd0);
      end else begin
        item = sb.pop_front();
        checkOutput($sformatf("v%0d_acc_inst", idx), inst, item.inst);
        checkOutput($sformatf("v%0d_acc_pc", idx), inst_pc, item.pc);
        checkOutput($sformatf("v%0d_acc_pc4", idx), inst_pc4, item.pc4);
      end
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d_req", idx), {31'd0, imem_req}, {31'd0, v.exp_req});
    checkOutput($sformatf("v%0d_addr", idx), imem_addr, v.exp_addr);
    checkOutput($sformatf("v%0d_valid", idx), {31'd0, inst_valid}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      checkOutput($sformatf("v%0d_inst_pc", idx), inst_pc, v.exp_pc);
      checkOutput($sformatf("v%0d_inst", idx), inst, mem_word(v.exp_pc));
      checkOutput($sformatf("v%0d_inst_pc4", idx), inst_pc4, v.exp_pc + 32'd4);
    end
    if (v.rst) begin
      checkOutput($sformatf("v%0d_rst_inst", idx), inst, 32'd0);
      checkOutput($sformatf("v%0d_rst_inst_pc", idx), inst_pc, 32'd0);
      checkOutput($sformatf("v%0d_rst_inst_pc4", idx), inst_pc4, 32'd0);
    end
    @(negedge clk);
  endtask

  // Main sequence: reset, table-driven traffic, then reset corner cases.
  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;

    // Reset
    applyStimulus(mk(I, O, 32'h0, O, O, O, O, O, 32'h0, O, 32'h0), 0);
    applyStimulus(mk(I, O, 32'h0, O, O, O, O, O, 32'h0, O, 32'h0), 1);

    // Zero-wait streaming with ready=1: one instruction every 2 cycles
    vecs.push_back(mk(O, O, 32'h0, I, I, I, O, O, 32'h4,  I, 32'h0));
    vecs.push_back(mk(O, O, 32'h0, I, I, O, O, I, 32'h4,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0, I, I, I, O, O, 32'h8,  I, 32'h4));
    vecs.push_back(mk(O, O, 32'h0, I, I, O, O, I, 32'h8,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0, I, I, I, O, O, 32'hC,  I, 32'h8));
    vecs.push_back(mk(O, O, 32'h0, I, I, O, O, I, 32'hC,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0, I, I, I, O, O, 32'h10, I, 32'hC));
    // Back-pressure in HOLD for 5 cycles, ack ignored without a request
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(O, O, 32'h0, I, O, O, O, O, 32'h10, I, 32'hC));
    vecs.push_back(mk(O, O, 32'h0, O, I, O, O, I, 32'h10, O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0, I, O, I, O, O, 32'h14, I, 32'h10));
    vecs.push_back(mk(O, O, 32'h0, O, I, O, O, I, 32'h14, O, 32'h0));
    // Ack and redirect together in FETCH, then 3-cycle memory squashed to 0x40
    vecs.push_back(mk(O, I, 32'h8,  I, O, O, O, I, 32'h8,  O, 32'h0));
    vecs.push_back(mk(O, I, 32'h40, O, O, O, O, I, 32'h8,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0,  O, O, O, O, I, 32'h8,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0,  I, O, O, O, I, 32'h40, O, 32'h0));
    // Several redirects while draining: the latest one wins
    vecs.push_back(mk(O, I, 32'h20,  O, O, O, O, I, 32'h40,  O, 32'h0));
    vecs.push_back(mk(O, I, 32'h40,  O, O, O, O, I, 32'h40,  O, 32'h0));
    vecs.push_back(mk(O, I, 32'h80,  O, O, O, O, I, 32'h40,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0,   I, O, O, O, I, 32'h80,  O, 32'h0));
    vecs.push_back(mk(O, I, 32'h200, O, O, O, O, I, 32'h80,  O, 32'h0));
    vecs.push_back(mk(O, I, 32'h300, I, O, O, O, I, 32'h300, O, 32'h0));
    // Redirect with ready in HOLD flushes the held instruction
    vecs.push_back(mk(O, O, 32'h0,  I, O, I, O, O, 32'h304, I, 32'h300));
    vecs.push_back(mk(O, I, 32'h40, O, I, O, I, I, 32'h40,  O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0,  I, O, I, O, O, 32'h44,  I, 32'h40));
    // Unaligned redirect near the top of memory, PC wraps to 0
    vecs.push_back(mk(O, I, 32'hFFFF_FFFE, O, O, O, I, I, 32'hFFFF_FFFC, O, 32'h0));
    vecs.push_back(mk(O, O, 32'h0, I, O, I, O, O, 32'h0, I, 32'hFFFF_FFFC));
    vecs.push_back(mk(O, O, 32'h0, O, I, O, O, I, 32'h0, O, 32'h0));

    foreach (vecs[n]) applyStimulus(vecs[n], n + 2);

    // Reset while a wrong-path request is draining
    applyStimulus(mk(O, I, 32'h500, I, O, O, O, I, 32'h500, O, 32'h0), 100);
    applyStimulus(mk(O, I, 32'h40,  O, O, O, O, I, 32'h500, O, 32'h0), 101);
    applyStimulus(mk(I, O, 32'h0,   O, O, O, O, O, 32'h0,   O, 32'h0), 102);
    applyStimulus(mk(O, O, 32'h0,   I, O, I, O, O, 32'h4,   I, 32'h0), 103);
    // Reset while holding an instruction drops it
    applyStimulus(mk(I, O, 32'h0,   O, O, O, I, O, 32'h0,   O, 32'h0), 104);
    applyStimulus(mk(O, O, 32'h0,   I, I, I, O, O, 32'h4,   I, 32'h0), 105);
    applyStimulus(mk(O, O, 32'h0,   O, I, O, O, I, 32'h4,   O, 32'h0), 106);

    checkOutput("sb_left_over", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
